// File: rtl/memory_responder.sv
// memory_responder: single-port word memory answering core fetch/load/store requests after WAIT_CYCLES wait states.
module memory_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_rdata,
  input  logic                 init_we,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic [DATA_BITS-1:0] init_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  state_t state, next_state;
  logic [3:0] cnt;
  logic lat_write, accept, cur_write;
  logic [ADDR_BITS-1:0] lat_addr, cur_addr;
  logic [DATA_BITS-1:0] lat_wdata, cur_wdata;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  assign req_ready  = reset_n && state == IDLE && !init_we;
  assign accept     = req_valid && req_ready;
  assign resp_valid = state == RESPOND;
  // with zero wait states the response data is captured on the accept edge itself
  assign cur_write = accept ? req_write : lat_write;
  assign cur_addr  = accept ? req_addr  : lat_addr;
  assign cur_wdata = accept ? req_wdata : lat_wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (state == IDLE && accept) next_state = (WAIT_CYCLES > 0) ? WAIT : RESPOND;
    else if (state == WAIT && cnt == 4'd0) next_state = RESPOND;
    else if (state == RESPOND) next_state = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (next_state == RESPOND && state != RESPOND) resp_rdata <= cur_write ? cur_wdata : mem[cur_addr];
    end
  // storage is never reset; a reset forces IDLE so an aborted store never lands
  always_ff @(posedge clk)
    if (state == IDLE && init_we) mem[init_addr] <= init_data;
    else if (state == RESPOND && lat_write) mem[lat_addr] <= lat_wdata;
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, meaning memory address width (matches MEMORY_ADDRESS_BITS).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning memory word width (matches MEMORY_DATA_BITS).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning wait states inserted before each response.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1, meaning the core presents a fetch, load or store request.
REQ-007 The block SHALL have port req_write, input, 1, meaning 1 = store, 0 = read (instruction fetch or load).
REQ-008 The block SHALL have port req_addr, input, ADDR_BITS, meaning the word address.
REQ-009 The block SHALL have port req_wdata, input, DATA_BITS, meaning the store data.
REQ-010 The block SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, DATA_BITS, meaning read data, or echoed store data on a write completion.
REQ-013 The block SHALL have port init_we, input, 1, meaning a preload write strobe for program loading.
REQ-014 The block SHALL have port init_addr, input, ADDR_BITS, meaning the preload address.
REQ-015 The block SHALL have port init_data, input, DATA_BITS, meaning the preload data.

Function
REQ-016 Storage SHALL be 2**ADDR_BITS words of DATA_BITS; addresses cover the full range, with no out-of-range case.
REQ-017 The FSM SHALL have states IDLE, WAIT, RESPOND.
REQ-018 req_ready SHALL be 1 only in IDLE and only when init_we = 0.
REQ-019 On req_valid & req_ready the block SHALL latch req_write, req_addr and req_wdata; the request is accepted in that cycle.
REQ-020 After acceptance the FSM SHALL go IDLE->WAIT if WAIT_CYCLES > 0, else IDLE->RESPOND.
REQ-021 In WAIT, a 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; at 0 the FSM goes to RESPOND.
REQ-022 In RESPOND, resp_valid SHALL be 1 for exactly one cycle and the FSM then returns to IDLE.
REQ-023 Accept-to-resp_valid latency SHALL be WAIT_CYCLES+1 cycles; back-to-back requests issue at most one every WAIT_CYCLES+2 cycles.
REQ-024 A read SHALL place mem[latched addr] on resp_rdata in the RESPOND cycle.
REQ-025 A write SHALL update mem[latched addr] at the RESPOND clock edge and drive the latched wdata on resp_rdata.
REQ-026 resp_rdata SHALL hold its last value while resp_valid = 0.
REQ-027 init_we SHALL write init_data to init_addr on the same edge, only in IDLE; it is ignored in WAIT and RESPOND.
REQ-028 If init_we and req_valid are both 1 in IDLE, the preload write SHALL win and the request SHALL not be accepted (req_ready = 0).
REQ-029 req_write, req_addr and req_wdata changes after acceptance SHALL not affect the in-flight transaction.
REQ-030 A read of an address written by the immediately preceding store SHALL return the new data.

Reset
REQ-031 reset_n = 0 SHALL asynchronously force: state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, and latched request registers 0.
REQ-032 req_ready SHALL be 0 while reset_n = 0 and SHALL be 1 in the first cycle after release when init_we = 0.
REQ-033 Memory contents SHALL not be cleared by reset.
REQ-034 Reset mid-transaction SHALL abort it: no resp_valid is produced, and a pending store is not written.

Verification
REQ-035 Preload and fetch: init_we writes 0x5A to 0x10; in IDLE, read 0x10 with WAIT_CYCLES = 1 -> resp_valid exactly 2 cycles after accept, resp_rdata = 0x5A.
REQ-036 Store then load: write 0xC3 to 0xFF, then read 0xFF -> write response echoes 0xC3; read returns 0xC3; req_ready = 0 during WAIT and RESPOND.
REQ-037 WAIT_CYCLES = 0: read 0x00 holding 0x01 -> resp_valid 1 cycle after accept; next request accepted in the following cycle.
REQ-038 Collision: init_we = 1 and req_valid = 1 in IDLE -> req_ready = 0, preload applied, request accepted the next cycle after init_we drops.
REQ-039 Reset mid-store: accept a write of 0xAA to 0x20 (old value 0x11), assert reset_n = 0 in WAIT -> no resp_valid; read 0x20 after reset returns 0x11.
REQ-040 Address wrap: reads of 0x00 and 0xFF return their distinct preloaded values; a write to 0xFF leaves 0x00 unchanged.
